mux_sel_arbiter: RTL and testbench

Clocked arbiter that sits directly upstream of the two-input tristate multiplexer and drives its select input. Two requesters compete for the shared mux output. The block grants one requester at a time and steers `sel`. On every select change it inserts a break-before-make settle window, so no grant is issued while the pmos/nmos tristate pair may still be contending. It also bounds how long one requester can hold the mux while the other waits.

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/dead_timer.sv | 25 ++
 rtl/mux_sel_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and defaults for the mux select arbiter
package mux_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_A,
    OWN_A,
    SET_B,
    OWN_B
  } arb_state_t;

  typedef enum logic {
    OWN_IS_A,
    OWN_IS_B
  } owner_t;

  localparam int DEAD_CYC_DEFAULT = 2;
  localparam int HOLD_MAX_DEFAULT = 8;

endpackage

// File: rtl/dead_timer.sv
// rtl/dead_timer.sv - 4-bit loadable down-counter timing the select dead window
module dead_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-requester mux select arbiter with break-before-make settle; MUX_ARB_ROUND_ROBIN_EN selects round-robin ties
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEFAULT,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic settle
);

  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [3:0]    DEAD_LOAD = 4'(DEAD_CYC - 1);

  arb_state_t    state;
  owner_t        last_owner;
  logic [HW-1:0] hold_cnt;
  logic          dead_load;
  logic          dead_done;
  logic          tie_to_b;
  logic          win_b;

  // The timer is held at DEAD_CYC-1 outside the settle states, so it is
  // already loaded on the edge that enters SET_x and counts down inside it.
  assign dead_load = (state != SET_A) && (state != SET_B);

  dead_timer u_dead_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dead_load),
    .load_val (DEAD_LOAD),
    .done     (dead_done)
  );

  // Tie rule: last_owner is tracked in both builds, only round-robin uses it.
`ifdef MUX_ARB_ROUND_ROBIN_EN
  assign tie_to_b = (last_owner == OWN_IS_A);
`else
  assign tie_to_b = 1'b0 & (last_owner == OWN_IS_A);
`endif

  assign win_b = req_b && (!req_a || tie_to_b);

  // Arbitration FSM with registered outputs and the hold (preemption) counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      settle     <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= OWN_IS_B;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (req_a || req_b) begin
            if (win_b) begin
              if (sel) begin
                state      <= OWN_B;
                gnt_b      <= 1'b1;
                last_owner <= OWN_IS_B;
              end else begin
                state  <= SET_B;
                sel    <= 1'b1;
                settle <= 1'b1;
              end
            end else begin
              if (!sel) begin
                state      <= OWN_A;
                gnt_a      <= 1'b1;
                last_owner <= OWN_IS_A;
              end else begin
                state  <= SET_A;
                sel    <= 1'b0;
                settle <= 1'b1;
              end
            end
          end
        end

        SET_A: begin
          if (!req_a) begin
            state  <= IDLE;
            settle <= 1'b0;
          end else if (dead_done) begin
            state      <= OWN_A;
            settle     <= 1'b0;
            gnt_a      <= 1'b1;
            last_owner <= OWN_IS_A;
          end
        end

        SET_B: begin
          if (!req_b) begin
            state  <= IDLE;
            settle <= 1'b0;
          end else if (dead_done) begin
            state      <= OWN_B;
            settle     <= 1'b0;
            gnt_b      <= 1'b1;
            last_owner <= OWN_IS_B;
          end
        end

        OWN_A: begin
          if (!req_a) begin
            state    <= IDLE;
            gnt_a    <= 1'b0;
            hold_cnt <= '0;
          end else if (req_b) begin
            if ((HOLD_MAX != 0) && (hold_cnt == HOLD_LAST)) begin
              state    <= SET_B;
              gnt_a    <= 1'b0;
              sel      <= 1'b1;
              settle   <= 1'b1;
              hold_cnt <= '0;
            end else if (hold_cnt != {HW{1'b1}}) begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end else begin
            hold_cnt <= '0;
          end
        end

        OWN_B: begin
          if (!req_b) begin
            state    <= IDLE;
            gnt_b    <= 1'b0;
            hold_cnt <= '0;
          end else if (req_a) begin
            if ((HOLD_MAX != 0) && (hold_cnt == HOLD_LAST)) begin
              state    <= SET_A;
              gnt_b    <= 1'b0;
              sel      <= 1'b0;
              settle   <= 1'b1;
              hold_cnt <= '0;
            end else if (hold_cnt != {HW{1'b1}}) begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end else begin
            hold_cnt <= '0;
          end
        end

        default: begin
          state  <= IDLE;
          gnt_a  <= 1'b0;
          gnt_b  <= 1'b0;
          settle <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - directed self-checking bench for mux_sel_arbiter
module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic sel, gnt_a, gnt_b, settle;

  logic req_a0 = 1'b0;
  logic req_b0 = 1'b0;
  logic sel0, gnt_a0, gnt_b0, settle0;

  int tests = 0;
  int fails = 0;

  logic [3:0] obs;
  logic [3:0] obs0;
  assign obs  = {sel, gnt_a, gnt_b, settle};
  assign obs0 = {sel0, gnt_a0, gnt_b0, settle0};

  always #5 clk = ~clk;

  mux_sel_arbiter #(.DEAD_CYC(2), .HOLD_MAX(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .req_b  (req_b),
    .sel    (sel),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .settle (settle)
  );

  mux_sel_arbiter #(.DEAD_CYC(2), .HOLD_MAX(0)) dut_nohold (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a0),
    .req_b  (req_b0),
    .sel    (sel0),
    .gnt_a  (gnt_a0),
    .gnt_b  (gnt_b0),
    .settle (settle0)
  );

  // Outputs compared as {sel, gnt_a, gnt_b, settle}.
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state while rst is held
    #1;
    check("reset_hold", obs, 4'b0000);
    check("reset_hold_nohold", obs0, 4'b0000);
    step();
    step();
    rst = 1'b0;

    // Grant without switch: sel already 0
    req_a = 1'b1;
    step();
    check("grant_a_direct", obs, 4'b0100);
    step();
    check("grant_a_held", obs, 4'b0100);

    // Release
    req_a = 1'b0;
    step();
    check("release_a", obs, 4'b0000);
    step();
    check("idle_after_release", obs, 4'b0000);

    // Grant with switch, DEAD_CYC=2
    req_b = 1'b1;
    step();
    check("switch_b_settle1", obs, 4'b1001);
    step();
    check("switch_b_settle2", obs, 4'b1001);
    step();
    check("switch_b_grant", obs, 4'b1010);

    // Asynchronous reset mid-OWN_B
    #2;
    rst = 1'b1;
    #1;
    check("reset_async_own_b", obs, 4'b0000);
    step();
    check("reset_held_own_b", obs, 4'b0000);
    rst = 1'b0;
    step();
    check("resume_from_idle", obs, 4'b1001);

    // Abort during settle
    req_b = 1'b0;
    step();
    check("abort_settle", obs, 4'b1000);
    step();
    check("abort_no_grant", obs, 4'b1000);

    // Tie after reset: A wins
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    check("tie_first_a", obs, 4'b0100);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    check("tie_release", obs, 4'b0000);
    req_a = 1'b1;
    req_b = 1'b1;
    step();
`ifdef MUX_ARB_ROUND_ROBIN_EN
    check("tie_second", obs, 4'b1001);
`else
    check("tie_second", obs, 4'b0100);
`endif
    req_a = 1'b0;
    req_b = 1'b0;
    step();

    // Preemption with HOLD_MAX=3
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 1'b1;
    step();
    check("preempt_own_a", obs, 4'b0100);
    req_b = 1'b1;
    step();
    check("preempt_hold1", obs, 4'b0100);
    step();
    check("preempt_hold2", obs, 4'b0100);
    step();
    check("preempt_switch", obs, 4'b1001);
    step();
    check("preempt_settle2", obs, 4'b1001);
    step();
    check("preempt_grant_b", obs, 4'b1010);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    check("preempt_release_b", obs, 4'b1000);

    // HOLD_MAX=0: A keeps the grant while B waits
    req_a0 = 1'b1;
    step();
    check("nohold_own_a", obs0, 4'b0100);
    req_b0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("nohold_keep_%0d", i), obs0, 4'b0100);
    end
    req_a0 = 1'b0;
    step();
    check("nohold_release_a", obs0, 4'b0000);
    step();
    check("nohold_b_settle", obs0, 4'b1001);
    req_b0 = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
